// File: rtl/wb_write_buffer_if.sv
// MEM-to-WB transfer, RF write and ID forwarding signals of the WB write buffer.
// LANES and WPORTS must match the parameters of the attached wb_write_buffer.
interface wb_write_buffer_if #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned WPORTS = 1
);
    logic                   mem_to_wb_valid;
    logic [LANES*70-1:0]    mem_to_wb_bus;
    logic                   wb_ready;
    logic                   stallreq;
    logic [WPORTS*38-1:0]   wb_to_rf_bus;
    logic [4:0]             fwd_raddr0;
    logic [4:0]             fwd_raddr1;
    logic                   fwd_hit0;
    logic                   fwd_hit1;
    logic [31:0]            fwd_data0;
    logic [31:0]            fwd_data1;
    logic [31:0]            debug_wb_pc;
    logic [3:0]             debug_wb_rf_wen;
    logic [4:0]             debug_wb_rf_wnum;
    logic [31:0]            debug_wb_rf_wdata;

    modport slave (
        input  mem_to_wb_valid, mem_to_wb_bus, fwd_raddr0, fwd_raddr1,
        output wb_ready, stallreq, wb_to_rf_bus, fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
        output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );

    modport master (
        output mem_to_wb_valid, mem_to_wb_bus, fwd_raddr0, fwd_raddr1,
        input  wb_ready, stallreq, wb_to_rf_bus, fwd_hit0, fwd_hit1, fwd_data0, fwd_data1,
        input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
    );
endinterface

// File: rtl/wb_write_buffer.sv
// Multi-lane WB pending-write FIFO draining up to WPORTS RF writes per cycle.
// Define WB_FWD_EN to build the ID forwarding lookup over buffered entries.
module wb_write_buffer #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned WPORTS = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wb_write_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_enq, n_deq;

    logic [31:0] pc_mem   [DEPTH];
    logic [4:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic              ready, accept;
    logic [LANES-1:0]  lane_keep;
    logic [PW-1:0]     lane_idx [LANES];
    logic [WPORTS*38-1:0] rf_bus;
    logic [PW-1:0]     port_idx;
    logic              port_we;

    // No credit for same-cycle dequeues: space must already exist for all lanes.
    assign ready  = count_q <= CW'(DEPTH - LANES);
    assign accept = bus.mem_to_wb_valid & ready;

    always_comb begin
        n_enq = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_keep[l] = accept && bus.mem_to_wb_bus[l*70+37]
                           && (bus.mem_to_wb_bus[l*70+32 +: 5] != 5'd0);
            lane_idx[l]  = wr_ptr_q + n_enq[PW-1:0];
            if (lane_keep[l]) n_enq = n_enq + CW'(1);
        end
    end

    always_comb begin
        n_deq    = (count_q < CW'(WPORTS)) ? count_q : CW'(WPORTS);
        count_d  = count_q + n_enq - n_deq;
        wr_ptr_d = wr_ptr_q + n_enq[PW-1:0];
        rd_ptr_d = rd_ptr_q + n_deq[PW-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_keep[l]) begin
                pc_mem[lane_idx[l]]   <= bus.mem_to_wb_bus[l*70+38 +: 32];
                addr_mem[lane_idx[l]] <= bus.mem_to_wb_bus[l*70+32 +: 5];
                data_mem[lane_idx[l]] <= bus.mem_to_wb_bus[l*70 +: 32];
            end
        end
    end

    // An older port loses its write enable when a younger driven port hits the same register.
    always_comb begin
        rf_bus   = '0;
        port_idx = '0;
        port_we  = 1'b0;
        for (int p = 0; p < WPORTS; p++) begin
            if (CW'(p) < count_q) begin
                port_idx = rd_ptr_q + PW'(p);
                port_we  = 1'b1;
                for (int q = p + 1; q < WPORTS; q++) begin
                    if (CW'(q) < count_q && addr_mem[rd_ptr_q + PW'(q)] == addr_mem[port_idx])
                        port_we = 1'b0;
                end
                rf_bus[p*38 +: 38] = {port_we, addr_mem[port_idx], data_mem[port_idx]};
            end
        end
    end

    assign bus.wb_ready          = ready;
    assign bus.stallreq          = bus.mem_to_wb_valid & ~ready;
    assign bus.wb_to_rf_bus      = rf_bus;
    assign bus.debug_wb_rf_wen   = {4{rf_bus[37]}};
    assign bus.debug_wb_rf_wnum  = rf_bus[36:32];
    assign bus.debug_wb_rf_wdata = rf_bus[31:0];
    assign bus.debug_wb_pc       = (count_q != '0) ? pc_mem[rd_ptr_q] : 32'd0;

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match leaves the youngest data.
    always_comb begin
        bus.fwd_hit0  = 1'b0;
        bus.fwd_hit1  = 1'b0;
        bus.fwd_data0 = 32'd0;
        bus.fwd_data1 = 32'd0;
        fwd_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                fwd_idx = rd_ptr_q + PW'(i);
                if (bus.fwd_raddr0 != 5'd0 && addr_mem[fwd_idx] == bus.fwd_raddr0) begin
                    bus.fwd_hit0  = 1'b1;
                    bus.fwd_data0 = data_mem[fwd_idx];
                end
                if (bus.fwd_raddr1 != 5'd0 && addr_mem[fwd_idx] == bus.fwd_raddr1) begin
                    bus.fwd_hit1  = 1'b1;
                    bus.fwd_data1 = data_mem[fwd_idx];
                end
            end
        end
    end
`else
    assign bus.fwd_hit0  = 1'b0;
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data0 = 32'd0;
    assign bus.fwd_data1 = 32'd0;
`endif
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed table-driven bench for wb_write_buffer: one WPORTS=1 and one WPORTS=2 instance.
module tb_wb_write_buffer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    wb_write_buffer_if #(.LANES(2), .WPORTS(1)) bus1 ();
    wb_write_buffer_if #(.LANES(2), .WPORTS(2)) bus2 ();

    wb_write_buffer #(.LANES(2), .WPORTS(1), .DEPTH(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
    wb_write_buffer #(.LANES(2), .WPORTS(2), .DEPTH(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic         valid;
        logic [139:0] lanes;
        logic [4:0]   ra0, ra1;
        logic         e_ready, e_stall;
        logic [37:0]  e_rf;
        logic [31:0]  e_pc;
        logic         e_hit0;
        logic [31:0]  e_d0;
        logic         e_hit1;
        logic [31:0]  e_d1;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [69:0] ln(logic we, logic [4:0] a, logic [31:0] d, logic [31:0] pc);
        return {pc, we, a, d};
    endfunction

    function automatic logic [37:0] rf(logic [4:0] a, logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic vec_t mk(logic v, logic [139:0] l, logic [4:0] a0, logic [4:0] a1,
                                logic rdy, logic stl, logic [37:0] r, logic [31:0] pc,
                                logic h0, logic [31:0] d0, logic h1, logic [31:0] d1);
        vec_t t;
        t.valid = v; t.lanes = l; t.ra0 = a0; t.ra1 = a1;
        t.e_ready = rdy; t.e_stall = stl; t.e_rf = r; t.e_pc = pc;
        t.e_hit0 = h0; t.e_d0 = d0; t.e_hit1 = h1; t.e_d1 = d1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_out1(input string tag, input vec_t v);
        chk({tag, " ready"}, 64'(bus1.wb_ready), 64'(v.e_ready));
        chk({tag, " stall"}, 64'(bus1.stallreq), 64'(v.e_stall));
        chk({tag, " rf"}, 64'(bus1.wb_to_rf_bus), 64'(v.e_rf));
        chk({tag, " pc"}, 64'(bus1.debug_wb_pc), 64'(v.e_pc));
        chk({tag, " wen"}, 64'(bus1.debug_wb_rf_wen), 64'({4{v.e_rf[37]}}));
        chk({tag, " wnum"}, 64'(bus1.debug_wb_rf_wnum), 64'(v.e_rf[36:32]));
        chk({tag, " wdata"}, 64'(bus1.debug_wb_rf_wdata), 64'(v.e_rf[31:0]));
        chk({tag, " hit0"}, 64'(bus1.fwd_hit0), 64'(FwdEn & v.e_hit0));
        chk({tag, " data0"}, 64'(bus1.fwd_data0), FwdEn ? 64'(v.e_d0) : 64'd0);
        chk({tag, " hit1"}, 64'(bus1.fwd_hit1), 64'(FwdEn & v.e_hit1));
        chk({tag, " data1"}, 64'(bus1.fwd_data1), FwdEn ? 64'(v.e_d1) : 64'd0);
    endtask

    initial begin
        // valid, lanes{lane1,lane0}, ra0, ra1, ready, stall, rf, pc, hit0, d0, hit1, d1
        vecs[0]  = mk(0, '0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, {ln(1, 4, 32'h22, 32'h104), ln(1, 3, 32'h11, 32'h100)},
                      0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, '0, 3, 0, 1, 0, rf(3, 32'h11), 32'h100, 1, 32'h11, 0, 0);
        vecs[3]  = mk(0, '0, 3, 0, 1, 0, rf(4, 32'h22), 32'h104, 0, 0, 0, 0);
        vecs[4]  = mk(0, '0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, {ln(0, 6, 32'h66, 32'h114), ln(1, 0, 32'h55, 32'h110)},
                      0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, '0, 6, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, {ln(1, 2, 32'h2, 32'h124), ln(1, 1, 32'h1, 32'h120)},
                      0, 0, 1, 0, '0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, {ln(1, 5, 32'hB, 32'h134), ln(1, 5, 32'hA, 32'h130)},
                      0, 0, 1, 0, rf(1, 32'h1), 32'h120, 0, 0, 0, 0);
        vecs[9]  = mk(1, {ln(1, 9, 32'h9, 32'h144), ln(1, 8, 32'h8, 32'h140)},
                      5, 0, 0, 1, rf(2, 32'h2), 32'h124, 1, 32'hB, 0, 0);
        vecs[10] = mk(1, {ln(1, 9, 32'h9, 32'h144), ln(1, 8, 32'h8, 32'h140)},
                      5, 0, 1, 0, rf(5, 32'hA), 32'h130, 1, 32'hB, 0, 0);
        vecs[11] = mk(0, '0, 9, 8, 0, 0, rf(5, 32'hB), 32'h134, 1, 32'h9, 1, 32'h8);
        vecs[12] = mk(0, '0, 5, 8, 1, 0, rf(8, 32'h8), 32'h140, 0, 0, 1, 32'h8);
        vecs[13] = mk(0, '0, 0, 0, 1, 0, rf(9, 32'h9), 32'h144, 0, 0, 0, 0);
        vecs[14] = mk(0, '0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0);

        bus1.mem_to_wb_valid = 1'b1;
        bus1.mem_to_wb_bus   = {ln(1, 4, 32'h22, 0), ln(1, 3, 32'h11, 0)};
        bus1.fwd_raddr0 = 5'd3; bus1.fwd_raddr1 = 5'd4;
        bus2.mem_to_wb_valid = 1'b0; bus2.mem_to_wb_bus = '0;
        bus2.fwd_raddr0 = 5'd0; bus2.fwd_raddr1 = 5'd0;

        // Held in reset across edges with valid high: nothing may enter.
        repeat (2) @(negedge clk);
        chk("rst ready", 64'(bus1.wb_ready), 64'd1);
        chk("rst stall", 64'(bus1.stallreq), 64'd0);
        chk("rst rf", 64'(bus1.wb_to_rf_bus), 64'd0);
        chk("rst pc", 64'(bus1.debug_wb_pc), 64'd0);
        chk("rst hit0", 64'(bus1.fwd_hit0), 64'd0);
        bus1.mem_to_wb_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus1.mem_to_wb_valid = vecs[i].valid;
            bus1.mem_to_wb_bus   = vecs[i].lanes;
            bus1.fwd_raddr0      = vecs[i].ra0;
            bus1.fwd_raddr1      = vecs[i].ra1;
            #2;
            chk_out1($sformatf("v%0d", i), vecs[i]);
        end

        // Fill to three entries, then pulse reset between edges.
        @(negedge clk);
        bus1.mem_to_wb_valid = 1'b1;
        bus1.mem_to_wb_bus   = {ln(1, 11, 32'hB1, 32'h204), ln(1, 10, 32'hA1, 32'h200)};
        @(negedge clk);
        bus1.mem_to_wb_bus   = {ln(1, 13, 32'hD1, 32'h20C), ln(1, 12, 32'hC1, 32'h208)};
        @(negedge clk);
        bus1.mem_to_wb_valid = 1'b0;
        bus1.fwd_raddr0      = 5'd12;
        bus1.fwd_raddr1      = 5'd0;
        #1;
        chk("pre ready", 64'(bus1.wb_ready), 64'd0);
        chk("pre rf", 64'(bus1.wb_to_rf_bus), 64'(rf(11, 32'hB1)));
        chk("pre pc", 64'(bus1.debug_wb_pc), 64'h204);
        chk("pre hit0", 64'(bus1.fwd_hit0), 64'(FwdEn));
        chk("pre data0", 64'(bus1.fwd_data0), FwdEn ? 64'hC1 : 64'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async rf", 64'(bus1.wb_to_rf_bus), 64'd0);
        chk("async pc", 64'(bus1.debug_wb_pc), 64'd0);
        chk("async wen", 64'(bus1.debug_wb_rf_wen), 64'd0);
        chk("async ready", 64'(bus1.wb_ready), 64'd1);
        chk("async hit0", 64'(bus1.fwd_hit0), 64'd0);
        chk("async data0", 64'(bus1.fwd_data0), 64'd0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            chk($sformatf("post%0d rf", c), 64'(bus1.wb_to_rf_bus), 64'd0);
            chk($sformatf("post%0d ready", c), 64'(bus1.wb_ready), 64'd1);
            chk($sformatf("post%0d pc", c), 64'(bus1.debug_wb_pc), 64'd0);
        end

        // Two write ports: same-register collision, then distinct registers.
        @(negedge clk);
        bus2.mem_to_wb_valid = 1'b1;
        bus2.mem_to_wb_bus   = {ln(1, 7, 32'h2, 32'h304), ln(1, 7, 32'h1, 32'h300)};
        @(negedge clk);
        bus2.mem_to_wb_bus   = {ln(1, 4, 32'h44, 32'h30C), ln(1, 3, 32'h33, 32'h308)};
        #2;
        chk("col p0 we", 64'(bus2.wb_to_rf_bus[37]), 64'd0);
        chk("col p1", 64'(bus2.wb_to_rf_bus[75:38]), 64'(rf(7, 32'h2)));
        chk("col wen", 64'(bus2.debug_wb_rf_wen), 64'd0);
        chk("col pc", 64'(bus2.debug_wb_pc), 64'h300);
        @(negedge clk);
        bus2.mem_to_wb_valid = 1'b0;
        #2;
        chk("dual p0", 64'(bus2.wb_to_rf_bus[37:0]), 64'(rf(3, 32'h33)));
        chk("dual p1", 64'(bus2.wb_to_rf_bus[75:38]), 64'(rf(4, 32'h44)));
        chk("dual wen", 64'(bus2.debug_wb_rf_wen), 64'hF);
        @(negedge clk);
        #2;
        chk("drain p0", 64'(bus2.wb_to_rf_bus[37:0]), 64'd0);
        chk("drain p1", 64'(bus2.wb_to_rf_bus[75:38]), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 Parameter LANES, default 2, number of MEM-to-WB write lanes per transfer (1..4).
REQ-002 Parameter WPORTS, default 1, number of RF write ports driven per cycle (1..LANES).
REQ-003 Parameter DEPTH, default 4, pending-write buffer entries (power of 2, >= LANES).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 mem_to_wb_valid  in  1  transfer offered by MEM.
REQ-007 mem_to_wb_bus  in  LANES*70  per lane {pc[31:0], we, waddr[4:0], wdata[31:0]}, lane 0 oldest in the LSB slice.
REQ-008 wb_ready  out  1  buffer accepts a transfer this cycle.
REQ-009 stallreq  out  1  upstream stall request.
REQ-010 wb_to_rf_bus  out  WPORTS*38  per port {we, waddr[4:0], wdata[31:0]}, port 0 oldest.
REQ-011 fwd_raddr0, fwd_raddr1  in  5 each  ID forwarding lookup addresses.
REQ-012 fwd_hit0, fwd_hit1  out  1 each; fwd_data0, fwd_data1  out  32 each  forwarding results.
REQ-013 debug_wb_pc  out  32; debug_wb_rf_wen  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32  mirror of port 0.

Function
REQ-014 Accept occurs on the rising edge where mem_to_wb_valid and wb_ready are both 1.
REQ-015 On accept, every lane with we=1 and waddr!=0 is enqueued in lane order; lanes with we=0 or waddr=0 are dropped.
REQ-016 wb_ready = (DEPTH - count) >= LANES, computed from the current count with no credit for same-cycle dequeues.
REQ-017 stallreq = mem_to_wb_valid & ~wb_ready.
REQ-018 Each cycle, the oldest min(count, WPORTS) entries drive wb_to_rf_bus ports 0..k-1 combinationally from the buffer head; unused ports drive all zeros.
REQ-019 Driven entries are dequeued at the next rising edge; enqueue and dequeue in the same cycle are both performed, and count updates by enqueued minus dequeued.
REQ-020 Latency: an entry accepted at edge t into an empty buffer is driven during the cycle following edge t.
REQ-021 Ordering: strict FIFO order; wrap-around of the read and write pointers at DEPTH is seamless.
REQ-022 Port collision: if two driven ports target the same waddr, the older port drives we=0 so that the younger data wins.
REQ-023 Forwarding: fwd_hitN = 1 when any buffered entry, including entries being driven this cycle, matches fwd_raddrN.
REQ-024 On a forwarding hit, fwd_dataN = wdata of the youngest matching entry; fwd_raddrN=0 never hits; on a miss, fwd_dataN = 0.
REQ-025 debug_wb_rf_wen = {4{port0 we}}; debug_wb_pc = pc of the entry at port 0, or 0 when the buffer is empty.

Reset
REQ-026 rst=0 asynchronously clears the pointers and count and drives every output to 0 except wb_ready.
REQ-027 wb_ready reads 1 while rst=0 and after its release.
REQ-028 Reset asserted mid-operation discards all pending entries, and no RF write is driven in the first cycle after release.

Configuration
REQ-029 With macro WB_FWD_EN defined, the forwarding lookup of REQ-023 and REQ-024 is implemented.
REQ-030 Without WB_FWD_EN, fwd_hit0, fwd_hit1, fwd_data0 and fwd_data1 are constant 0 and no lookup logic is synthesised.

Verification (LANES=2, WPORTS=1, DEPTH=4, WB_FWD_EN defined unless noted)
REQ-031 Two-lane accept of {$3=0x11, $4=0x22} -> port 0 drives $3/0x11 in the next cycle, $4/0x22 one cycle later, then all zeros.
REQ-032 Back-to-back accepts each writing two lanes -> count reaches 3, wb_ready=0, and stallreq=1 while valid is held; wb_ready returns to 1 when count<=2.
REQ-033 Lane 0 {we=1, $0} with lane 1 {we=0} -> nothing enqueued, count stays 0, and wb_to_rf_bus stays all zeros.
REQ-034 Buffer holding $5=0xA then $5=0xB with fwd_raddr0=5 and fwd_raddr1=0 -> fwd_hit0=1, fwd_data0=0xB, fwd_hit1=0; without WB_FWD_EN, all forwarding outputs read 0.
REQ-035 With WPORTS=2, head entries $7=0x1 then $7=0x2 -> port 0 we=0 and port 1 drives $7/0x2.
REQ-036 With 3 entries pending, rst pulsed low between clock edges -> outputs go to 0 immediately, and after release count=0, wb_ready=1 and no write is driven.
